keypad_scan_encoder: RTL and testbench

- Scans a 4x4 matrix keypad, debounces it, and encodes the result onto the 5-bit key_stats bus consumed by the calculator core.
- Codes 0x0–0xF mean a key is held; 0x10 means idle.
- The calculator acts on key_stats *changes*, so every release must return the bus to 0x10.
- Sits between the board keypad pins and the calculator core.

---
 rtl/keypad_pkg.sv | 21 ++
 rtl/keypad_debounce.sv | 73 +++++++
 rtl/keypad_scan_encoder.sv | 85 ++++++++
 tb/tb_keypad_scan_encoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes and the {row,col} keymap shared by the keypad scan encoder.
package keypad_pkg;
    localparam logic [4:0] KEY_NONE = 5'h10;
    localparam logic [4:0] KEY_ADD  = 5'hA;
    localparam logic [4:0] KEY_SUB  = 5'hB;
    localparam logic [4:0] KEY_MUL  = 5'hC;
    localparam logic [4:0] KEY_DIV  = 5'hD;
    localparam logic [4:0] KEY_BACK = 5'hE;
    localparam logic [4:0] KEY_CLR  = 5'hF;

    localparam logic [4:0] KEYMAP [16] = '{
        5'h1,    5'h2, 5'h3,     KEY_ADD,
        5'h4,    5'h5, 5'h6,     KEY_SUB,
        5'h7,    5'h8, 5'h9,     KEY_MUL,
        KEY_CLR, 5'h0, KEY_BACK, KEY_DIV
    };

    function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
        return KEYMAP[{r, c}];
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-rate candidate/stable-count filter driving key_stats and key_strobe.
// KEYPAD_REPEAT_EN adds auto-repeat: a held code drops to KEY_NONE for one frame every REPEAT_FRAMES frames.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 100
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_valid,
    input  logic [4:0] frame_code,
    output logic [4:0] key_stats,
    output logic       key_strobe
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [4:0]    cand_q;
    logic [4:0]    stats_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          strobe_q;
    logic          upd;
    logic          gap;

    always_comb begin
        cnt_d = frame_code != cand_q ? CW'(1) : cnt_q == CW'(DEBOUNCE_CNT) ? cnt_q : cnt_q + 1'b1;
        upd   = cnt_d == CW'(DEBOUNCE_CNT) && frame_code != stats_q;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);

    logic [RW-1:0] rep_q;

    always_comb gap = !upd && stats_q != KEY_NONE && rep_q == RW'(REPEAT_FRAMES - 1);

    // Counts frames a non-idle code has sat unchanged on the bus.
    always_ff @(posedge CLK) begin
        if (RST)
            rep_q <= '0;
        else if (frame_valid)
            rep_q <= (upd || gap || frame_code != stats_q || stats_q == KEY_NONE) ? '0 : rep_q + 1'b1;
    end
`else
    always_comb gap = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            cand_q   <= KEY_NONE;
            cnt_q    <= '0;
            stats_q  <= KEY_NONE;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= frame_valid && upd && frame_code != KEY_NONE;
            if (frame_valid) begin
                cand_q <= frame_code;
                cnt_q  <= cnt_d;
                if (upd)
                    stats_q <= frame_code;
                else if (gap)
                    stats_q <= KEY_NONE;
            end
        end
    end

    assign key_stats  = stats_q;
    assign key_strobe = strobe_q;
endmodule

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: 4x4 keypad column scanner, frame decoder and debounced key_stats encoder.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE_CNT = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 100
`endif
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] key_stats,
    output logic       key_strobe
);
    localparam int SW = $clog2(SCAN_DIV);

    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [SW-1:0] slot_q;
    logic [1:0]    col_q;
    logic [1:0]    hits_q;
    logic [1:0]    hits_d;
    logic [4:0]    code_q;
    logic [4:0]    code_d;
    logic [3:0]    pressed;
    logic [2:0]    col_hits;
    logic [2:0]    hit_sum;
    logic [1:0]    row_sel;
    logic          slot_end;
    logic          frame_end;
    logic [4:0]    frame_code;

    // hits saturates at 2: any multi-key or ghost pattern decodes to idle.
    always_comb begin
        pressed    = ~sync2_q;
        col_hits   = 3'(pressed[0]) + 3'(pressed[1]) + 3'(pressed[2]) + 3'(pressed[3]);
        hit_sum    = 3'(hits_q) + col_hits;
        row_sel    = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
        slot_end   = slot_q == SW'(SCAN_DIV - 1);
        frame_end  = slot_end && col_q == 2'd3;
        hits_d     = slot_end ? (hit_sum >= 3'd2 ? 2'd2 : hit_sum[1:0]) : hits_q;
        code_d     = slot_end && col_hits == 3'd1 ? key_code(row_sel, col_q) : code_q;
        frame_code = hits_d == 2'd1 ? code_d : KEY_NONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= '1;
            sync2_q <= '1;
            slot_q  <= '0;
            col_q   <= '0;
            hits_q  <= '0;
            code_q  <= KEY_NONE;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
            slot_q  <= slot_end ? '0 : slot_q + 1'b1;
            col_q   <= slot_end ? col_q + 1'b1 : col_q;
            hits_q  <= frame_end ? '0 : hits_d;
            code_q  <= frame_end ? KEY_NONE : code_d;
        end
    end

    assign col_out = ~(4'b0001 << col_q);

    keypad_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_FRAMES(REPEAT_FRAMES)
`endif
    ) u_debounce (
        .CLK        (CLK),
        .RST        (RST),
        .frame_valid(frame_end),
        .frame_code (frame_code),
        .key_stats  (key_stats),
        .key_strobe (key_strobe)
    );
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb_keypad_scan_encoder: keypad matrix model, per-frame vector table and key_stats change scoreboard.
module tb_keypad_scan_encoder;
    import keypad_pkg::*;

    typedef struct {
        logic [15:0] mask;
        logic [4:0]  exp;
    } step_t;

    typedef struct {
        logic [4:0] code;
        logic       strobe;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [4:0]  key_stats;
    logic        key_strobe;
    logic [15:0] press = '0;
    logic        mon_en = 1'b0;
    logic [4:0]  last_ks;
    int          phase = 0;
    int          pass_cnt = 0;
    int          total = 0;
    step_t       steps[$];
    ev_t         sb[$];

    keypad_scan_encoder #(
        .SCAN_DIV(4),
`ifdef KEYPAD_REPEAT_EN
        .REPEAT_FRAMES(5),
`endif
        .DEBOUNCE_CNT(3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_stats (key_stats),
        .key_strobe(key_strobe)
    );

    always #5 CLK = ~CLK;

    // Pressed switch at (r,c) pulls row r low while column c is driven low.
    always_comb
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(press[r*4 +: 4] & ~col_out);

    always @(posedge CLK) phase <= RST ? 0 : (phase + 1) % 16;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (!mon_en) begin
            last_ks = key_stats;
        end else if (key_stats !== last_ks) begin
            if (sb.size() == 0) begin
                chk("unexpected key_stats change", key_stats, last_ks);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("change code", key_stats, e.code);
                chk("change strobe", key_strobe, e.strobe);
                chk("change on frame end", phase, 0);
            end
            last_ks = key_stats;
        end else if (key_strobe) begin
            chk("stray strobe", key_strobe, 0);
        end
    end

    task automatic run_frame(input logic [15:0] m, input logic [4:0] exp, input string nm);
        press = m;
        chk("col_out at frame start", col_out, 4'b1110);
        repeat (16) @(posedge CLK);
        #1;
        chk(nm, key_stats, exp);
    endtask

    task automatic add(input logic [15:0] m, input logic [4:0] exp, input int n);
        for (int k = 0; k < n; k++) steps.push_back('{m, exp});
    endtask

    initial begin
        logic [4:0] prev;
        // idle / single press r1c1 / release
        add(16'h0000, KEY_NONE, 2);
        add(16'h0020, KEY_NONE, 2);
        add(16'h0020, 5'h5, 4);
        add(16'h0000, 5'h5, 2);
        add(16'h0000, KEY_NONE, 1);
        // bounce on r3c0 then hold
        for (int k = 0; k < 2; k++) begin
            add(16'h1000, KEY_NONE, 1);
            add(16'h0000, KEY_NONE, 1);
        end
        add(16'h1000, KEY_NONE, 2);
        add(16'h1000, KEY_CLR, 1);
        add(16'h0000, KEY_CLR, 2);
        add(16'h0000, KEY_NONE, 1);
        // ghost r0c0+r0c1, then r0c0 alone
        add(16'h0003, KEY_NONE, 5);
        add(16'h0001, KEY_NONE, 2);
        add(16'h0001, 5'h1, 1);
        add(16'h0000, 5'h1, 2);
        add(16'h0000, KEY_NONE, 1);
        // two keys in one column
        add(16'h0044, KEY_NONE, 3);
        // roll A -> D
        add(16'h0008, KEY_NONE, 2);
        add(16'h0008, KEY_ADD, 2);
        add(16'h8000, KEY_ADD, 2);
        add(16'h8000, KEY_DIV, 1);
        add(16'h0000, KEY_DIV, 2);
        add(16'h0000, KEY_NONE, 1);
        // long hold of r2c2
        for (int f = 1; f <= 20; f++)
`ifdef KEYPAD_REPEAT_EN
            add(16'h0400, f < 3 ? KEY_NONE : ((f - 3) % 6 == 5) ? KEY_NONE : 5'h9, 1);
        add(16'h0000, KEY_NONE, 3);
`else
            add(16'h0400, f < 3 ? KEY_NONE : 5'h9, 1);
        add(16'h0000, 5'h9, 2);
        add(16'h0000, KEY_NONE, 1);
`endif

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        mon_en = 1'b1;
        run_frame(16'h0020, KEY_NONE, "pre-reset hold 1");
        run_frame(16'h0020, KEY_NONE, "pre-reset hold 2");
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset col_out", col_out, 4'b1110);
        chk("reset key_stats", key_stats, KEY_NONE);
        chk("reset key_strobe", key_strobe, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("col_out holds col0 for 3 cycles", col_out, 4'b1110);
        @(posedge CLK);
        #1;
        chk("col_out advances after 4 cycles", col_out, 4'b1101);
        repeat (12) @(posedge CLK);
        #1;
        chk("debounce cleared by reset", key_stats, KEY_NONE);

        prev = KEY_NONE;
        foreach (steps[i]) begin
            if (steps[i].exp != prev) sb.push_back('{steps[i].exp, steps[i].exp != KEY_NONE});
            prev = steps[i].exp;
            run_frame(steps[i].mask, steps[i].exp, $sformatf("frame %0d key_stats", i));
        end
        repeat (4) @(posedge CLK);
        chk("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", pass_cnt, total);
        $fatal(1);
    end
endmodule
